// File: rtl/lsu_unit_pkg.sv
// Shared encodings for the load/store unit: FSM states, RV32I funct3 sizes,
// reset polarity and the legality check applied when a request is offered.
package lsu_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic       RST_ACT  = 1'b0;
    localparam logic [4:0] ZERO_REG = 5'd0;

    // Size lives in funct3[1:0]; halfwords need an even address, words a 4-byte one.
    function automatic logic op_legal(input logic we, input logic [2:0] f3, input logic [1:0] off);
        logic ok_f3;
        logic aligned;
        if (we)
            ok_f3 = (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
        else
            ok_f3 = (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
                    (f3 == F3_LBU) || (f3 == F3_LHU);
        case (f3[1:0])
            2'b01:   aligned = ~off[0];
            2'b10:   aligned = (off == 2'b00);
            default: aligned = 1'b1;
        endcase
        return ok_f3 && aligned;
    endfunction

endpackage

// File: rtl/lsu_unit_align.sv
// Lane steering: store byte enables/replication and load extract/extend.
// Latency: purely combinational.
// Backpressure: none, no state.
module lsu_unit_align
    import lsu_unit_pkg::*;
(
    input  logic [2:0]  st_funct3,
    input  logic [1:0]  st_offset,
    input  logic [31:0] st_wdata,
    output logic [3:0]  st_be,
    output logic [31:0] st_data,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_offset,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        st_be   = 4'b1111;
        st_data = st_wdata;
        case (st_funct3)
            F3_SB: begin
                st_be   = 4'b0001 << st_offset;
                st_data = {4{st_wdata[7:0]}};
            end
            F3_SH: begin
                st_be   = 4'b0011 << st_offset;
                st_data = {2{st_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_byte = ld_rdata[{ld_offset, 3'b000} +: 8];
        ld_half = ld_offset[1] ? ld_rdata[31:16] : ld_rdata[15:0];
        case (ld_funct3)
            F3_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
            F3_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
            F3_LBU:  ld_data = {24'd0, ld_byte};
            F3_LHU:  ld_data = {16'd0, ld_half};
            default: ld_data = ld_rdata;
        endcase
    end

endmodule

// File: rtl/lsu_unit.sv
// Multi-cycle load/store unit: one op at a time onto a req/gnt/rvalid data bus.
// Latency: store 1 cycle + grant wait; load 3 cycles minimum to write-back.
// Backpressure: req_ready only in IDLE; bus outputs held stable until mem_gnt.
module lsu_unit
    import lsu_unit_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [2:0]          req_funct3,
    input  logic [DATA_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [REG_AW-1:0]   req_rd,
    output logic                mem_req,
    output logic                mem_we,
    output logic [DATA_W-1:0]   mem_addr,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_gnt,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                sb_rd_we,
    output logic [REG_AW-1:0]   sb_rd_waddr,
    output logic [DATA_W-1:0]   sb_rd_wdata,
    output logic                lsu_busy,
    output logic                lsu_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    lsu_state_t        state;
    logic [2:0]        f3_q;
    logic [1:0]        off_q;
    logic [REG_AW-1:0] rd_q;
    logic [CNT_W-1:0]  cnt;
    logic              req_legal;
    logic              rd_live;
    logic [3:0]        al_be;
    logic [31:0]       al_wdata;
    logic [31:0]       al_ldata;

    assign req_ready = (state == ST_IDLE);
    assign lsu_busy  = ~req_ready;
    assign req_legal = op_legal(req_we, req_funct3, req_addr[1:0]);
    assign rd_live   = (rd_q != REG_AW'(ZERO_REG));

    lsu_unit_align u_align (
        .st_funct3 (req_funct3),
        .st_offset (req_addr[1:0]),
        .st_wdata  (req_wdata),
        .st_be     (al_be),
        .st_data   (al_wdata),
        .ld_funct3 (f3_q),
        .ld_offset (off_q),
        .ld_rdata  (mem_rdata),
        .ld_data   (al_ldata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ACT) begin
            state       <= ST_IDLE;
            f3_q        <= '0;
            off_q       <= '0;
            rd_q        <= '0;
            cnt         <= '0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_be      <= '0;
            mem_wdata   <= '0;
            sb_rd_we    <= 1'b0;
            sb_rd_waddr <= '0;
            sb_rd_wdata <= '0;
            lsu_err     <= 1'b0;
        end else begin
            // Write-back and error are single-cycle pulses; only the states below raise them.
            lsu_err     <= 1'b0;
            sb_rd_we    <= 1'b0;
            sb_rd_waddr <= '0;
            sb_rd_wdata <= '0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        if (req_legal) begin
                            state     <= ST_REQ;
                            mem_req   <= 1'b1;
                            mem_we    <= req_we;
                            mem_addr  <= {req_addr[DATA_W-1:2], 2'b00};
                            mem_be    <= req_we ? al_be : 4'b1111;
                            mem_wdata <= req_we ? al_wdata : '0;
                            f3_q      <= req_funct3;
                            off_q     <= req_addr[1:0];
                            rd_q      <= req_rd;
                            cnt       <= '0;
                        end else begin
                            lsu_err <= 1'b1;
                        end
                    end
                end
                ST_REQ: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        state   <= mem_we ? ST_IDLE : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (mem_rvalid) begin
                        sb_rd_we    <= rd_live;
                        sb_rd_waddr <= rd_q;
                        sb_rd_wdata <= rd_live ? al_ldata : '0;
                        state       <= ST_RESP;
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        lsu_err <= 1'b1;
                        state   <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_unit.sv
// Randomized bench for lsu_unit: driver pushes expected bus/write-back/error
// events into queues; negedge monitors pop and compare against DUT outputs.
module tb_lsu_unit;

    localparam int TIMEOUT = 255;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [4:0]  req_rd = '0;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        sb_rd_we;
    logic [4:0]  sb_rd_waddr;
    logic [31:0] sb_rd_wdata;
    logic        lsu_busy;
    logic        lsu_err;

    lsu_unit #(.DATA_W(32), .REG_AW(5), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .sb_rd_we(sb_rd_we), .sb_rd_waddr(sb_rd_waddr), .sb_rd_wdata(sb_rd_wdata),
        .lsu_busy(lsu_busy), .lsu_err(lsu_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    typedef struct { int cyc; logic [4:0] rd; logic [31:0] data; } wb_t;
    typedef struct { logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; } bus_t;
    typedef struct { int cyc; int tol; } err_t;

    wb_t  wb_q[$];
    bus_t bus_q[$];
    err_t err_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitors
    bus_t held;
    wb_t  mw;
    err_t me;
    logic prev_req = 1'b0;
    logic prev_gnt = 1'b0;

    always @(negedge clk) begin
        check("busy_vs_ready", 32'(lsu_busy), 32'(!req_ready));
        if (sb_rd_we) begin
            if (wb_q.size() == 0) begin
                check("wb_unexpected", 32'(sb_rd_we), 32'd0);
            end else begin
                mw = wb_q.pop_front();
                check("wb_cycle", cyc, mw.cyc);
                check("wb_waddr", 32'(sb_rd_waddr), 32'(mw.rd));
                check("wb_wdata", sb_rd_wdata, mw.data);
            end
        end else begin
            check("wb_idle_zero", sb_rd_wdata, 32'd0);
        end

        if (mem_req) begin
            if (prev_gnt) check("req_drop_after_gnt", 32'(mem_req), 32'd0);
            if (!prev_req) begin
                if (bus_q.size() == 0) check("bus_unexpected", 32'(mem_req), 32'd0);
                else held = bus_q.pop_front();
            end
            check("bus_we", 32'(mem_we), 32'(held.we));
            check("bus_addr", mem_addr, held.addr);
            check("bus_be", 32'(mem_be), 32'(held.be));
            if (held.we) check("bus_wdata", mem_wdata, held.wdata);
        end
        prev_req = mem_req;
        prev_gnt = mem_req && mem_gnt;

        if (lsu_err) begin
            if (err_q.size() == 0) begin
                check("err_unexpected", 32'(lsu_err), 32'd0);
            end else begin
                me = err_q.pop_front();
                total++;
                if (cyc < me.cyc - me.tol || cyc > me.cyc + me.tol) begin
                    bad++;
                    $display("FAIL err_cycle: got cycle %0d want %0d (+-%0d)", cyc, me.cyc, me.tol);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // mode 0: normal, 1: load never answered (timeout), 2: reset while waiting for data
    task automatic do_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] rd, input int gd,
                         input int rdl, input logic [31:0] rdata, input int mode);
        int k, n, off, sz;
        bit legal;
        logic [31:0] byte_v, half_v, exp_v, exp_wd;
        logic [3:0] exp_be;
        bus_t b;
        wb_t  w;
        err_t e;

        off = int'(addr[1:0]);
        sz  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        if ((off % sz) != 0) legal = 1'b0;

        n = 0;
        while (!req_ready && n < 50) begin step(); n++; end
        if (!req_ready) check("ready_wait_bound", 32'(req_ready), 32'd1);
        k = cyc;

        if (!legal) begin
            e.cyc = k + 1; e.tol = 0; err_q.push_back(e);
        end else begin
            if (!we) begin exp_be = 4'hF; exp_wd = 32'd0; end
            else if (sz == 1) begin exp_be = 4'(1 << off); exp_wd = (wdata % 256) * 32'h01010101; end
            else if (sz == 2) begin exp_be = 4'(3 << off); exp_wd = (wdata % 65536) * 32'h00010001; end
            else begin exp_be = 4'hF; exp_wd = wdata; end
            b.we = we; b.addr = addr - 32'(off); b.be = exp_be; b.wdata = exp_wd;
            bus_q.push_back(b);

            byte_v = (rdata >> (8 * off)) % 256;
            half_v = (rdata >> (8 * off)) % 65536;
            case (f3)
                3'd0:    exp_v = (byte_v >= 128) ? byte_v - 256 : byte_v;
                3'd1:    exp_v = (half_v >= 32768) ? half_v - 65536 : half_v;
                3'd4:    exp_v = byte_v;
                3'd5:    exp_v = half_v;
                default: exp_v = rdata;
            endcase
            if (!we && mode == 0 && rd != 0) begin
                w.cyc = k + 3 + gd + rdl; w.rd = rd; w.data = exp_v; wb_q.push_back(w);
            end
            if (!we && mode == 1) begin
                e.cyc = k + gd + 2 + TIMEOUT; e.tol = 1; err_q.push_back(e);
            end
        end

        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr;
        req_wdata = wdata; req_rd = rd;
        step();
        req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
        req_funct3 = 3'($urandom_range(0, 7)); req_rd = 5'($urandom_range(0, 31));
        if (!legal) begin
            step();
            return;
        end
        check("ready_low_when_busy", 32'(req_ready), 32'd0);

        repeat (gd) step();
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        if (we) return;

        if (mode == 0) begin
            repeat (rdl) step();
            mem_rvalid = 1'b1; mem_rdata = rdata;
            step();
            mem_rvalid = 1'b0; mem_rdata = $urandom;
            step();
        end else if (mode == 1) begin
            n = 0;
            while (!req_ready && n < TIMEOUT + 20) begin step(); n++; end
            check("timeout_back_to_idle", 32'(req_ready), 32'd1);
            step();
        end else begin
            step();
            rst = 1'b0;
            #1;
            check("rst_mem_req", 32'(mem_req), 32'd0);
            check("rst_mem_we", 32'(mem_we), 32'd0);
            check("rst_mem_addr", mem_addr, 32'd0);
            check("rst_mem_be", 32'(mem_be), 32'd0);
            check("rst_mem_wdata", mem_wdata, 32'd0);
            check("rst_sb_we", 32'(sb_rd_we), 32'd0);
            check("rst_sb_waddr", 32'(sb_rd_waddr), 32'd0);
            check("rst_sb_wdata", sb_rd_wdata, 32'd0);
            check("rst_err", 32'(lsu_err), 32'd0);
            step();
            rst = 1'b1;
            step();
            check("ready_after_rst", 32'(req_ready), 32'd1);
            mem_rvalid = 1'b1; mem_rdata = rdata;
            step();
            mem_rvalid = 1'b0;
            repeat (3) step();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    int lf[5] = '{0, 1, 2, 4, 5};

    initial begin
        logic        we_r;
        logic [2:0]  f3_r;
        logic [31:0] a_r;

        repeat (3) step();
        check("reset_mem_req", 32'(mem_req), 32'd0);
        check("reset_mem_be", 32'(mem_be), 32'd0);
        check("reset_sb_we", 32'(sb_rd_we), 32'd0);
        check("reset_err", 32'(lsu_err), 32'd0);
        rst = 1'b1;
        step();
        check("reset_ready", 32'(req_ready), 32'd1);
        check("reset_busy", 32'(lsu_busy), 32'd0);

        do_op(1'b0, 3'b010, 32'h0000_1000, 32'h0, 5'd5, 0, 0, 32'hDEADBEEF, 0);
        do_op(1'b0, 3'b000, 32'h0000_1003, 32'h0, 5'd6, 0, 0, 32'h80112233, 0);
        do_op(1'b0, 3'b100, 32'h0000_1003, 32'h0, 5'd6, 1, 2, 32'h80112233, 0);
        do_op(1'b0, 3'b101, 32'h0000_1002, 32'h0, 5'd7, 0, 1, 32'h80112233, 0);
        do_op(1'b0, 3'b001, 32'h0000_1002, 32'h0, 5'd8, 2, 0, 32'h80112233, 0);
        do_op(1'b1, 3'b001, 32'h0000_2002, 32'h0000ABCD, 5'd0, 3, 0, 32'h0, 0);
        do_op(1'b1, 3'b000, 32'h0000_2001, 32'h000000A5, 5'd0, 0, 0, 32'h0, 0);
        do_op(1'b0, 3'b010, 32'h0000_1001, 32'h0, 5'd5, 0, 0, 32'h0, 0);
        do_op(1'b0, 3'b011, 32'h0000_1000, 32'h0, 5'd5, 0, 0, 32'h0, 0);
        do_op(1'b1, 3'b100, 32'h0000_1000, 32'h0, 5'd0, 0, 0, 32'h0, 0);
        do_op(1'b0, 3'b010, 32'h0000_3000, 32'h0, 5'd9, 1, 0, 32'h0, 1);
        do_op(1'b0, 3'b010, 32'h0000_1000, 32'h0, 5'd0, 0, 0, 32'hCAFEF00D, 0);
        do_op(1'b0, 3'b010, 32'h0000_1004, 32'h0, 5'd3, 0, 0, 32'h12345678, 2);

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = $urandom;
                step();
                mem_gnt = 1'b0; mem_rvalid = 1'b0;
            end
            we_r = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 4) == 0) f3_r = 3'($urandom_range(0, 7));
            else if (we_r) f3_r = 3'($urandom_range(0, 2));
            else f3_r = 3'(lf[$urandom_range(0, 4)]);
            a_r = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (f3_r[1:0] == 2'd1) a_r[0] = 1'b0;
                if (f3_r[1:0] == 2'd2) a_r[1:0] = 2'b00;
            end
            do_op(we_r, f3_r, a_r, $urandom, 5'($urandom_range(0, 31)),
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom, 0);
        end

        repeat (5) step();
        check("wb_queue_drained", 32'(wb_q.size()), 32'd0);
        check("bus_queue_drained", 32'(bus_q.size()), 32'd0);
        check("err_queue_drained", 32'(err_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
